// File: rtl/axi_mem_responder.sv
// AXI4 slave that serves one transaction at a time from a single-port, always-ready SRAM.
// Supports FIXED/INCR bursts (WRAP behaves as INCR) and answers SLVERR outside the SRAM window.
module axi_mem_responder #(
    parameter int unsigned                AXI_ADDR_WIDTH = 32,
    parameter int unsigned                AXI_DATA_WIDTH = 32,
    parameter int unsigned                AXI_ID_WIDTH   = 4,
    parameter int unsigned                AXI_USER_WIDTH = 1,
    parameter logic [AXI_ADDR_WIDTH-1:0]  MEM_BASE_ADDR  = 32'h0010_0000,
    parameter int unsigned                MEM_WORDS      = 4096,
    localparam int unsigned               BW             = AXI_DATA_WIDTH / 8,
    localparam int unsigned               MEM_AW         = $clog2(MEM_WORDS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXI_ID_WIDTH-1:0]   aw_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0] aw_addr_i,
    input  logic [7:0]                aw_len_i,
    input  logic [1:0]                aw_burst_i,
    input  logic                      aw_valid_i,
    output logic                      aw_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0] w_data_i,
    input  logic [BW-1:0]             w_strb_i,
    input  logic                      w_last_i,
    input  logic                      w_valid_i,
    output logic                      w_ready_o,
    output logic [AXI_ID_WIDTH-1:0]   b_id_o,
    output logic [1:0]                b_resp_o,
    output logic [AXI_USER_WIDTH-1:0] b_user_o,
    output logic                      b_valid_o,
    input  logic                      b_ready_i,
    input  logic [AXI_ID_WIDTH-1:0]   ar_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0] ar_addr_i,
    input  logic [7:0]                ar_len_i,
    input  logic [1:0]                ar_burst_i,
    input  logic                      ar_valid_i,
    output logic                      ar_ready_o,
    output logic [AXI_ID_WIDTH-1:0]   r_id_o,
    output logic [AXI_DATA_WIDTH-1:0] r_data_o,
    output logic [1:0]                r_resp_o,
    output logic                      r_last_o,
    output logic [AXI_USER_WIDTH-1:0] r_user_o,
    output logic                      r_valid_o,
    input  logic                      r_ready_i,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [BW-1:0]             mem_be_o,
    output logic [MEM_AW-1:0]         mem_addr_o,
    output logic [AXI_DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [AXI_DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_MEM  = 3'd1,
        S_RD_RESP = 3'd2,
        S_WR_DATA = 3'd3,
        S_WR_RESP = 3'd4
    } state_e;

    localparam int unsigned               OFS        = $clog2(BW);
    localparam logic [AXI_ADDR_WIDTH-1:0] MEM_LIMIT  = MEM_BASE_ADDR + AXI_ADDR_WIDTH'(MEM_WORDS * BW);
    localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~(AXI_ADDR_WIDTH'(BW - 1));

    state_e                      state_q;
    logic                        prefer_rd_q;
    logic [AXI_ID_WIDTH-1:0]     id_q;
    logic [AXI_ADDR_WIDTH-1:0]   cur_addr_q;
    logic [AXI_ADDR_WIDTH-1:0]   cur_addr_d;
    logic [7:0]                  len_q;
    logic [7:0]                  beat_cnt_q;
    logic                        fixed_q;
    logic                        err_q;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q;
    logic                        rd_fresh_q;
    logic [1:0]                  rresp_q;
    logic                        rlast_q;
    logic                        in_range;
    logic                        last_beat;
    logic                        w_beat;

    assign in_range   = (cur_addr_q >= MEM_BASE_ADDR) && (cur_addr_q < MEM_LIMIT);
    assign last_beat  = (beat_cnt_q == len_q);
    assign cur_addr_d = fixed_q ? cur_addr_q : cur_addr_q + AXI_ADDR_WIDTH'(BW);

    // Reads win a tie unless the previous grant went to a read, so a pending pair alternates.
    assign ar_ready_o = (state_q == S_IDLE) && ar_valid_i && (prefer_rd_q || !aw_valid_i);
    assign aw_ready_o = (state_q == S_IDLE) && aw_valid_i && !ar_ready_o;
    assign w_ready_o  = (state_q == S_WR_DATA);
    assign w_beat     = w_ready_o && w_valid_i;
    assign r_valid_o  = (state_q == S_RD_RESP);
    assign b_valid_o  = (state_q == S_WR_RESP);

    // SRAM data arrives in the first RD_RESP cycle; afterwards the captured copy keeps it stable.
    assign r_data_o   = rd_fresh_q ? mem_rdata_i : rdata_q;
    assign r_resp_o   = rresp_q;
    assign r_last_o   = rlast_q;
    assign r_id_o     = id_q;
    assign r_user_o   = {AXI_USER_WIDTH{1'b0}};
    assign b_id_o     = id_q;
    assign b_resp_o   = (b_valid_o && err_q) ? 2'b10 : 2'b00;
    assign b_user_o   = {AXI_USER_WIDTH{1'b0}};

    assign mem_req_o   = in_range && ((state_q == S_RD_MEM) || w_beat);
    assign mem_we_o    = w_beat;
    assign mem_be_o    = w_beat ? w_strb_i : {BW{1'b1}};
    assign mem_addr_o  = MEM_AW'((cur_addr_q - MEM_BASE_ADDR) >> OFS);
    assign mem_wdata_o = w_data_i;

    // Transaction FSM: arbitration, burst sequencing and registered read/write response state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            prefer_rd_q <= 1'b1;
            id_q        <= {AXI_ID_WIDTH{1'b0}};
            cur_addr_q  <= {AXI_ADDR_WIDTH{1'b0}};
            len_q       <= 8'd0;
            beat_cnt_q  <= 8'd0;
            fixed_q     <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= {AXI_DATA_WIDTH{1'b0}};
            rd_fresh_q  <= 1'b0;
            rresp_q     <= 2'b00;
            rlast_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ar_ready_o) begin
                        id_q        <= ar_id_i;
                        cur_addr_q  <= ar_addr_i & ALIGN_MASK;
                        len_q       <= ar_len_i;
                        fixed_q     <= (ar_burst_i == 2'b00);
                        beat_cnt_q  <= 8'd0;
                        prefer_rd_q <= 1'b0;
                        state_q     <= S_RD_MEM;
                    end else if (aw_ready_o) begin
                        id_q        <= aw_id_i;
                        cur_addr_q  <= aw_addr_i & ALIGN_MASK;
                        len_q       <= aw_len_i;
                        fixed_q     <= (aw_burst_i == 2'b00);
                        beat_cnt_q  <= 8'd0;
                        err_q       <= 1'b0;
                        prefer_rd_q <= 1'b1;
                        state_q     <= S_WR_DATA;
                    end else begin
                        state_q     <= S_IDLE;
                    end
                end
                S_RD_MEM: begin
                    rd_fresh_q <= in_range;
                    rdata_q    <= {AXI_DATA_WIDTH{1'b0}};
                    rresp_q    <= in_range ? 2'b00 : 2'b10;
                    rlast_q    <= last_beat;
                    state_q    <= S_RD_RESP;
                end
                S_RD_RESP: begin
                    if (rd_fresh_q) begin
                        rdata_q    <= mem_rdata_i;
                        rd_fresh_q <= 1'b0;
                    end
                    if (r_ready_i) begin
                        if (rlast_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 8'd1;
                            cur_addr_q <= cur_addr_d;
                            state_q    <= S_RD_MEM;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (w_valid_i) begin
                        // Burst length comes from AWLEN; WLAST is only cross-checked.
                        if (!in_range || (w_last_i != last_beat)) begin
                            err_q <= 1'b1;
                        end
                        if (last_beat) begin
                            state_q <= S_WR_RESP;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 8'd1;
                            cur_addr_q <= cur_addr_d;
                        end
                    end
                end
                S_WR_RESP: begin
                    if (b_ready_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Self-checking bench for axi_mem_responder: directed corner cases, an address-range
// vector table and randomized bursts checked against a transaction-level memory model.
module tb_axi_mem_responder;

    localparam logic [31:0] BASE  = 32'h0010_0000;
    localparam int          WORDS = 4096;
    localparam logic [31:0] LIMIT = BASE + 32'(WORDS * 4);

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  aw_id, ar_id, b_id, r_id;
    logic [31:0] aw_addr, ar_addr;
    logic [7:0]  aw_len, ar_len;
    logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
    logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
    logic        ar_valid, ar_ready, r_last, r_valid, r_ready;
    logic [31:0] w_data, r_data;
    logic [3:0]  w_strb;
    logic [0:0]  b_user, r_user;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    axi_mem_responder #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1),
        .MEM_BASE_ADDR(BASE), .MEM_WORDS(WORDS)
    ) dut (
        .clk(clk), .rst(rst),
        .aw_id_i(aw_id), .aw_addr_i(aw_addr), .aw_len_i(aw_len), .aw_burst_i(aw_burst),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
        .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last), .w_valid_i(w_valid), .w_ready_o(w_ready),
        .b_id_o(b_id), .b_resp_o(b_resp), .b_user_o(b_user), .b_valid_o(b_valid), .b_ready_i(b_ready),
        .ar_id_i(ar_id), .ar_addr_i(ar_addr), .ar_len_i(ar_len), .ar_burst_i(ar_burst),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
        .r_id_o(r_id), .r_data_o(r_data), .r_resp_o(r_resp), .r_last_o(r_last), .r_user_o(r_user),
        .r_valid_o(r_valid), .r_ready_i(r_ready),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    // SRAM environment: data one cycle after a read request, noise on every other cycle.
    logic [31:0] sram [WORDS];
    logic        init_en = 1'b0;
    int          rd_req_cnt = 0;
    int          be_viol = 0;
    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < WORDS; i++) sram[i] <= 32'(i) * 32'h9E37_79B9;
            sram[5] <= 32'hDEAD_BEEF;
        end
        if (mem_req && mem_we) begin
            for (int k = 0; k < 4; k++)
                if (mem_be[k]) sram[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
        end
        if (mem_req && !mem_we) begin
            mem_rdata  <= sram[mem_addr];
            rd_req_cnt <= rd_req_cnt + 1;
            if (mem_be !== 4'hF) be_viol <= be_viol + 1;
        end else begin
            mem_rdata <= $urandom;
        end
    end

    // Reference model: expected memory contents, updated per accepted in-range write beat.
    logic [31:0] ref_mem [WORDS];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    int          total = 0;
    int          passed = 0;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  resp;
        int          nreq;
    } rvec_t;
    rvec_t vt [7];

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && (a < LIMIT);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ar_send(input logic [31:0] a, input logic [7:0] l, input logic [1:0] bu, input logic [3:0] id);
        int n = 0;
        ar_addr = a; ar_len = l; ar_burst = bu; ar_id = id; ar_valid = 1'b1;
        #1;
        while (!ar_ready && n < 50) begin tick(); n++; end
        if (!ar_ready) chk("ar_timeout", 64'(ar_ready), 64'd1);
        else tick();
        ar_valid = 1'b0;
    endtask

    task automatic aw_send(input logic [31:0] a, input logic [7:0] l, input logic [1:0] bu, input logic [3:0] id);
        int n = 0;
        aw_addr = a; aw_len = l; aw_burst = bu; aw_id = id; aw_valid = 1'b1;
        #1;
        while (!aw_ready && n < 50) begin tick(); n++; end
        if (!aw_ready) chk("aw_timeout", 64'(aw_ready), 64'd1);
        else tick();
        aw_valid = 1'b0;
    endtask

    task automatic read_data(input logic [31:0] addr, input logic [7:0] l, input logic [1:0] bu,
                             input logic [3:0] id, input int stall, output logic [1:0] last_resp);
        logic [31:0] a = addr & 32'hFFFF_FFFC;
        last_resp = 2'b11;
        for (int b = 0; b <= int'(l); b++) begin
            logic [31:0] ed;
            logic [1:0]  er;
            bit          lst;
            int          n = 0;
            while (!r_valid && n < 20) begin tick(); n++; end
            if (!r_valid) begin chk("r_timeout", 64'(r_valid), 64'd1); return; end
            ed  = in_rng(a) ? ref_mem[widx(a)] : 32'd0;
            er  = in_rng(a) ? 2'b00 : 2'b10;
            lst = (b == int'(l));
            chk("r_beat", 64'({r_data, r_resp, r_id, r_last}), 64'({ed, er, id, lst}));
            for (int s = 0; s < stall; s++) begin
                tick();
                chk("r_hold", 64'({r_valid, r_data, r_resp, r_last, mem_req}), 64'({1'b1, ed, er, lst, 1'b0}));
            end
            last_resp = r_resp;
            r_ready = 1'b1;
            tick();
            r_ready = 1'b0;
            if (bu != 2'b00) a = a + 32'd4;
        end
    endtask

    task automatic write_data(input logic [31:0] addr, input logic [7:0] l, input logic [1:0] bu,
                              input logic [3:0] id, input bit bad_last, output logic [1:0] bresp_seen);
        logic [31:0] a = addr & 32'hFFFF_FFFC;
        bit          eerr = 1'b0;
        int          nb = 0;
        bresp_seen = 2'b11;
        for (int b = 0; b <= int'(l); b++) begin
            int n = 0;
            bit lst = bad_last ? (b == 0) : (b == int'(l));
            w_data = wd[b]; w_strb = ws[b]; w_last = lst; w_valid = 1'b1;
            #1;
            while (!w_ready && n < 20) begin tick(); n++; end
            if (!w_ready) begin chk("w_timeout", 64'(w_ready), 64'd1); w_valid = 1'b0; return; end
            chk("w_req", 64'({mem_req, mem_we}), 64'({in_rng(a), 1'b1}));
            if (in_rng(a)) begin
                chk("w_mem", 64'({mem_be, mem_addr, mem_wdata}), 64'({ws[b], 12'(widx(a)), wd[b]}));
                for (int k = 0; k < 4; k++)
                    if (ws[b][k]) ref_mem[widx(a)][8*k +: 8] = wd[b][8*k +: 8];
            end else begin
                eerr = 1'b1;
            end
            if (lst != (b == int'(l))) eerr = 1'b1;
            tick();
            w_valid = 1'b0; w_last = 1'b0;
            if (bu != 2'b00) a = a + 32'd4;
        end
        b_ready = 1'b1;
        while (!b_valid && nb < 20) begin tick(); nb++; end
        if (!b_valid) begin
            chk("b_timeout", 64'(b_valid), 64'd1);
        end else begin
            chk("b_resp", 64'({b_resp, b_id}), 64'({eerr ? 2'b10 : 2'b00, id}));
            bresp_seen = b_resp;
            tick();
        end
        b_ready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [7:0] l, input logic [1:0] bu,
                           input logic [3:0] id, input int stall, output logic [1:0] rs);
        ar_send(a, l, bu, id);
        read_data(a, l, bu, id, stall, rs);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] l, input logic [1:0] bu,
                            input logic [3:0] id, input bit bad_last, output logic [1:0] bs);
        aw_send(a, l, bu, id);
        write_data(a, l, bu, id, bad_last, bs);
    endtask

    function automatic logic [63:0] idle_outputs();
        return 64'({aw_ready, w_ready, ar_ready, b_valid, r_valid, r_data, r_resp, b_resp,
                    r_id, b_id, r_last, mem_req, mem_we, b_user, r_user});
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rs;
        int         c0;

        rst = 1'b1; init_en = 1'b1;
        aw_id = '0; aw_addr = '0; aw_len = '0; aw_burst = '0; aw_valid = 1'b0;
        ar_id = '0; ar_addr = '0; ar_len = '0; ar_burst = '0; ar_valid = 1'b0;
        w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0; r_ready = 1'b0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'(i) * 32'h9E37_79B9;
        ref_mem[5] = 32'hDEAD_BEEF;
        vt[0] = '{BASE - 32'd4,      2'b10, 0};
        vt[1] = '{BASE,              2'b00, 1};
        vt[2] = '{LIMIT - 32'd4,     2'b00, 1};
        vt[3] = '{LIMIT,             2'b10, 0};
        vt[4] = '{BASE + 32'h15,     2'b00, 1};
        vt[5] = '{32'hFFFF_FFFC,     2'b10, 0};
        vt[6] = '{32'h0000_0000,     2'b10, 0};
        repeat (3) @(posedge clk);
        #1;
        init_en = 1'b0;
        chk("reset_outputs", idle_outputs(), 64'd0);
        rst = 1'b0;

        // T1: single read, latency and data
        ar_send(BASE + 32'h14, 8'd0, 2'b01, 4'd3);
        chk("t1_mem_read", 64'({mem_req, mem_we, mem_addr, r_valid}), 64'({1'b1, 1'b0, 12'd5, 1'b0}));
        tick();
        chk("t1_latency", 64'({r_valid, r_data}), 64'({1'b1, 32'hDEAD_BEEF}));
        read_data(BASE + 32'h14, 8'd0, 2'b01, 4'd3, 0, rs);

        // T2: INCR write burst then read-back
        for (int k = 0; k < 4; k++) begin wd[k] = 32'(k + 1); ws[k] = 4'hF; end
        do_write(BASE + 32'h20, 8'd3, 2'b01, 4'd7, 1'b0, rs);
        chk("t2_bresp", 64'(rs), 64'd0);
        do_read(BASE + 32'h20, 8'd3, 2'b01, 4'd9, 0, rs);

        // T3: read backpressure, then partial strobes
        c0 = rd_req_cnt;
        do_read(BASE + 32'h40, 8'd1, 2'b01, 4'd2, 5, rs);
        chk("t3_read_reqs", 64'(rd_req_cnt - c0), 64'd2);
        wd[0] = 32'hA5A5_A5A5; ws[0] = 4'b0101;
        do_write(BASE + 32'h40, 8'd0, 2'b01, 4'd4, 1'b0, rs);
        do_read(BASE + 32'h40, 8'd0, 2'b00, 4'd4, 0, rs);

        // T4: simultaneous AR/AW after reset, grants alternate
        rst = 1'b1; tick(); rst = 1'b0;
        ar_addr = BASE + 32'h20; ar_len = 8'd0; ar_burst = 2'b01; ar_id = 4'd1;
        aw_addr = BASE + 32'h30; aw_len = 8'd0; aw_burst = 2'b01; aw_id = 4'd2;
        ar_valid = 1'b1; aw_valid = 1'b1;
        #1;
        chk("t4_read_first", 64'({ar_ready, aw_ready}), 64'd2);
        tick(); ar_valid = 1'b0;
        read_data(BASE + 32'h20, 8'd0, 2'b01, 4'd1, 0, rs);
        ar_valid = 1'b1;
        #1;
        chk("t4_write_next", 64'({ar_ready, aw_ready}), 64'd1);
        tick(); aw_valid = 1'b0;
        wd[0] = 32'h1234_5678; ws[0] = 4'hF;
        write_data(BASE + 32'h30, 8'd0, 2'b01, 4'd2, 1'b0, rs);
        #1;
        chk("t4_read_again", 64'({ar_ready, aw_ready}), 64'd2);
        tick(); ar_valid = 1'b0;
        read_data(BASE + 32'h20, 8'd0, 2'b01, 4'd1, 0, rs);

        // T5: address-range vectors
        for (int v = 0; v < 7; v++) begin
            c0 = rd_req_cnt;
            do_read(vt[v].addr, 8'd0, 2'b01, 4'(v), 0, rs);
            chk("range_vec", 64'({rs, 8'(rd_req_cnt - c0)}), 64'({vt[v].resp, 8'(vt[v].nreq)}));
        end
        wd[0] = 32'hCAFE_0001; wd[1] = 32'hCAFE_0002; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(BASE + 32'h100, 8'd1, 2'b01, 4'd5, 1'b1, rs);
        chk("t5_early_wlast", 64'(rs), 64'd2);
        do_read(BASE + 32'h100, 8'd1, 2'b01, 4'd5, 0, rs);
        do_write(LIMIT - 32'd4, 8'd1, 2'b01, 4'd6, 1'b0, rs);
        chk("t5_cross_limit", 64'(rs), 64'd2);
        for (int k = 0; k < 3; k++) begin wd[k] = 32'h5000_0000 + 32'(k); ws[k] = 4'hF; end
        do_write(BASE + 32'h200, 8'd2, 2'b00, 4'd8, 1'b0, rs);
        do_read(BASE + 32'h200, 8'd2, 2'b00, 4'd8, 0, rs);

        // T6: reset in the middle of a read burst
        ar_send(BASE + 32'h60, 8'd3, 2'b01, 4'd6);
        c0 = 0;
        while (!r_valid && c0 < 20) begin tick(); c0++; end
        chk("t6_first_beat", 64'(r_valid), 64'd1);
        r_ready = 1'b1; tick(); r_ready = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_reset_outputs", idle_outputs(), 64'd0);
        tick();
        chk("t6_quiet", 64'({r_valid, b_valid, mem_req}), 64'd0);
        do_read(BASE + 32'h60, 8'd3, 2'b01, 4'd6, 0, rs);

        // Longest burst
        for (int k = 0; k < 256; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
        do_write(BASE + 32'h400, 8'd255, 2'b01, 4'd10, 1'b0, rs);
        do_read(BASE + 32'h400, 8'd255, 2'b01, 4'd11, 0, rs);

        // Randomized mix of reads and writes against the model
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            logic [7:0]  l;
            logic [1:0]  bu;
            l  = 8'($urandom_range(0, 7));
            bu = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 5) == 0) a = LIMIT - 32'(4 * $urandom_range(0, 3));
            else a = BASE + 32'(4 * $urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k <= int'(l); k++) begin wd[k] = $urandom; ws[k] = 4'($urandom); end
                do_write(a, l, bu, 4'($urandom), ($urandom_range(0, 9) == 0), rs);
            end else begin
                do_read(a, l, bu, 4'($urandom), int'($urandom_range(0, 2)), rs);
            end
        end

        chk("read_be_all_ones", 64'(be_viol), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
